// File: rtl/pixel_binner.sv
// Averages non-overlapping BIN_X x BIN_Y blocks of a row-major pixel stream and
// emits the reduced frame on an AXI-Stream master with tlast and a frame_done pulse.
module pixel_binner #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
    input  logic [$clog2(IN_COLS)-1:0]   s_cnt_col,
    input  logic [$clog2(IN_ROWS)-1:0]   s_cnt_row,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         frame_done
);
    localparam int BIN_X   = IN_COLS / OUT_COLS;
    localparam int BIN_Y   = IN_ROWS / OUT_ROWS;
    localparam int LOG_BX  = $clog2(BIN_X);
    localparam int LOG_BY  = $clog2(BIN_Y);
    localparam int LOG_BIN = LOG_BX + LOG_BY;
    localparam int SUM_W   = PIXEL_BIT_WIDTH + LOG_BIN;
    localparam int COL_W   = $clog2(IN_COLS);
    localparam int ROW_W   = $clog2(IN_ROWS);
    localparam int OC_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int OR_W    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state, state_nxt;
    logic               frame_done_nxt;
    logic [SUM_W-1:0]   h_acc;
    logic [SUM_W-1:0]   line [OUT_COLS];

    logic               accept, out_hs;
    logic [COL_W-1:0]   bx;
    logic [ROW_W-1:0]   by;
    logic [OC_W-1:0]    oc;
    logic [OR_W-1:0]    orow;
    logic               col_end, row_first, row_last;
    logic [SUM_W-1:0]   psum, line_sum, bin_sum;

    // Truncating average: the bin area is a power of two, so divide is a shift.
    function automatic logic [PIXEL_BIT_WIDTH-1:0] bin_avg(input logic [SUM_W-1:0] sum);
        return PIXEL_BIT_WIDTH'(sum >> LOG_BIN);
    endfunction

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_hs        = m_axis_tvalid && m_axis_tready;

    assign bx        = s_cnt_col & COL_W'(BIN_X - 1);
    assign by        = s_cnt_row & ROW_W'(BIN_Y - 1);
    assign oc        = OC_W'(s_cnt_col >> LOG_BX);
    assign orow      = OR_W'(s_cnt_row >> LOG_BY);
    assign col_end   = (bx == COL_W'(BIN_X - 1));
    assign row_first = (by == '0);
    assign row_last  = (by == ROW_W'(BIN_Y - 1));

    assign psum     = h_acc + SUM_W'(s_axis_tdata);
    assign line_sum = line[oc] + psum;
    // With a single-row bin the line entry is never written, so use psum alone.
    assign bin_sum  = row_first ? psum : line_sum;

    // Accumulation and output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            h_acc         <= '0;
            for (int i = 0; i < OUT_COLS; i++) line[i] <= '0;
        end else begin
            if (out_hs) m_axis_tvalid <= 1'b0;
            if (accept) begin
                if (!col_end) begin
                    h_acc <= psum;
                end else begin
                    h_acc <= '0;
                    if (row_last) begin
                        m_axis_tdata  <= bin_avg(bin_sum);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (orow == OR_W'(OUT_ROWS - 1)) &&
                                         (oc == OC_W'(OUT_COLS - 1));
                    end else if (row_first) begin
                        line[oc] <= psum;
                    end else begin
                        line[oc] <= line_sum;
                    end
                end
            end
        end
    end

    // Frame tracking stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = out_hs && m_axis_tlast;
        case (state)
            IDLE:    if (accept) state_nxt = ACTIVE;
            ACTIVE:  if (out_hs && m_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_binner.sv
// Scoreboard bench for pixel_binner: driver pushes expected bin averages as it
// issues each bin's final pixel, a negedge monitor pops and compares outputs.
module tb_pixel_binner;
    localparam int PW    = 10;
    localparam int IR    = 20;
    localparam int IC    = 20;
    localparam int OR    = 10;
    localparam int OC    = 10;
    localparam int BX    = IC / OC;
    localparam int BY    = IR / OR;
    localparam int COL_W = $clog2(IC);
    localparam int ROW_W = $clog2(IR);

    logic             clk = 1'b0;
    logic             reset;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [PW-1:0]    s_axis_tdata;
    logic [COL_W-1:0] s_cnt_col;
    logic [ROW_W-1:0] s_cnt_row;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [PW-1:0]    m_axis_tdata;
    logic             m_axis_tlast;
    logic             frame_done;

    pixel_binner #(
        .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_cnt_col(s_cnt_col), .s_cnt_row(s_cnt_row),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   img[IR][IC];
    int   fd_count = 0;
    int   out_count = 0;
    int   rdy_mode = 0;
    bit   stall_pending = 0;
    int   stall_cnt = 0;
    int   stall_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Downstream ready: always high, random, or a single 5-cycle stall on the first valid.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: m_axis_tready = ($urandom_range(0, 1) == 1);
            2: begin
                if (stall_pending && m_axis_tvalid) begin
                    stall_pending = 0;
                    stall_cnt = 5;
                end
                if (stall_cnt > 0) begin
                    m_axis_tready = 1'b0;
                    stall_cnt--;
                end else begin
                    m_axis_tready = 1'b1;
                end
            end
            default: m_axis_tready = 1'b1;
        endcase
    end

    int  prev_data;
    bit  prev_stall = 0;
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_count++;
        if (prev_stall && !reset) begin
            check("hold_tvalid", int'(m_axis_tvalid), 1);
            check("hold_tdata", int'(m_axis_tdata), prev_data);
        end
        prev_stall = 0;
        if (m_axis_tvalid) begin
            if (m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("tdata", int'(m_axis_tdata), e.data);
                    check("tlast", int'(m_axis_tlast), e.last);
                    out_count++;
                end
            end else begin
                check("s_tready_during_stall", int'(s_axis_tready), 0);
                stall_seen++;
                prev_stall = 1;
                prev_data = int'(m_axis_tdata);
            end
        end
    end

    // mode 0 ramp, 1 all-max, 2 all-zero, 3 random pixels
    task automatic send_frame(input int mode, input int gap_pct, input int max_pix);
        int n = 0;
        for (int r = 0; r < IR; r++)
            for (int c = 0; c < IC; c++)
                case (mode)
                    0: img[r][c] = r * IC + c;
                    1: img[r][c] = (1 << PW) - 1;
                    2: img[r][c] = 0;
                    default: img[r][c] = $urandom_range(0, (1 << PW) - 1);
                endcase
        for (int r = 0; r < IR; r++) begin
            for (int c = 0; c < IC; c++) begin
                int w;
                if (n >= max_pix) return;
                while ($urandom_range(0, 99) < gap_pct) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = PW'(img[r][c]);
                s_cnt_col     = COL_W'(c);
                s_cnt_row     = ROW_W'(r);
                if ((r % BY == BY - 1) && (c % BX == BX - 1)) begin
                    exp_t e;
                    int sum = 0;
                    for (int dr = 0; dr < BY; dr++)
                        for (int dc = 0; dc < BX; dc++)
                            sum += img[r - dr][c - dc];
                    e.data = sum / (BX * BY);
                    e.last = (r == IR - 1 && c == IC - 1) ? 1 : 0;
                    sb.push_back(e);
                end
                w = 0;
                forever begin
                    @(negedge clk);
                    if (s_axis_tready) break;
                    w++;
                    if (w > 1000) begin
                        $display("FAIL accept_timeout actual=stalled expected=accept");
                        failures++;
                        $fatal(1, "input never accepted");
                    end
                end
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        s_axis_tvalid = 1'b0;
        while (sb.size() != 0 && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    task automatic run_frames(input string name, input int mode, input int gap,
                              input int nframes);
        int fd0 = fd_count;
        int oc0 = out_count;
        for (int f = 0; f < nframes; f++) send_frame(mode, gap, IR * IC);
        drain({name, "_drain"});
        check({name, "_outputs"}, out_count - oc0, nframes * OR * OC);
        check({name, "_frame_done"}, fd_count - fd0, nframes);
    endtask

    initial begin
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_cnt_col = '0;
        s_cnt_row = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tvalid", int'(m_axis_tvalid), 0);
        check("reset_tlast", int'(m_axis_tlast), 0);
        check("reset_tdata", int'(m_axis_tdata), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_s_tready", int'(s_axis_tready), 1);
        @(posedge clk); #1;

        rdy_mode = 0;
        run_frames("ramp", 0, 0, 1);
        run_frames("all_max", 1, 0, 1);
        run_frames("all_zero", 2, 0, 1);

        rdy_mode = 2;
        stall_seen = 0;
        stall_pending = 1;
        run_frames("stall", 0, 0, 1);
        check("stall_cycles", stall_seen, 5);

        rdy_mode = 1;
        run_frames("random_ramp", 0, 30, 1);
        run_frames("random_data", 3, 30, 1);

        rdy_mode = 0;
        @(posedge clk); #1;
        send_frame(0, 0, 150);
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_tvalid", int'(m_axis_tvalid), 0);
        check("post_reset_queue", sb.size(), 0);
        @(posedge clk); #1;
        run_frames("after_reset", 0, 0, 1);

        run_frames("back_to_back", 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
